fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that owns the program counter and drives the instruction-memory request port. It consumes the 2-bit next-PC select produced by the branch-resolution logic, together with the branch target and ALU result. It delivers fetched instructions with their PC to decode over a valid/ready handshake. Only one memory request is outstanding at a time; a small skid buffer absorbs decode backpressure.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value of `if_instr` when no instruction is held

- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- branch  input  2  next-PC select: 00 PC+4, 01 branch target, 10 ALU_OUT, 11 reserved
- branch_valid  input  1  `branch` and the target inputs are valid this cycle
- branch_target  input  32  PC-relative target, used when `branch`=01
- alu_out  input  32  jump target from the ALU, used when `branch`=10
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address, word-aligned
- imem_gnt  input  1  address accepted in a cycle where `imem_req`&`imem_gnt`
- imem_rvalid  input  1  single-cycle response strobe, at least 1 cycle after the grant
- imem_rdata  input  32  instruction word, valid with `imem_rvalid`
- if_valid  output  1  decode-side instruction valid
- if_ready  input  1  decode accepts the instruction when `if_valid`&`if_ready`
- if_pc  output  32  PC of `if_instr`
- if_instr  output  32  instruction word

## Operation
- Redirect condition: `branch_valid` and `branch` is 01 or 10.
  - `branch`=00 or 11 never redirects; 11 is ignored silently.
- Redirect target: `branch_target` (01) or `alu_out` (10), with bits [1:0] forced to 0.
- Registers:
  - `fetch_pc`: next address to request.
  - `inflight_pc`: PC of the granted request.
  - `kill`: drop the next response.
  - Output buffer: `if_valid`/`if_pc`/`if_instr`.
  - Skid entry: valid, pc, instr.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`fetch_pc` whenever the skid is empty.
  - On grant: `inflight_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to WAIT.
  - `imem_addr` may change between cycles while ungranted; memory samples it only on grant.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid` with `kill`=1: discard the data, clear `kill`, go to FETCH.
  - On `imem_rvalid` with `kill`=0: if the buffer is empty, or is being drained this cycle, load the buffer {`inflight_pc`, `imem_rdata`} and go to FETCH. Otherwise write the skid and go to HOLD.
- HOLD:
  - `imem_req`=0.
  - When the buffer drains, the skid moves to the buffer and the FSM goes to FETCH.
- Redirect (any state):
  - `fetch_pc`←target.
  - Buffer and skid are invalidated: `if_valid`=0 next cycle.
  - A pending drain that cycle still counts as a handshake.
  - In WAIT, or in FETCH with a grant in the same cycle: `kill`←1 and the FSM ends in WAIT.
  - In HOLD, or in WAIT with `imem_rvalid` in the same cycle: the response is dropped and the FSM goes to FETCH.
- Redirect has priority over every other update in the same cycle.
- While `if_valid`=1 and `if_ready`=0, `if_pc`/`if_instr` are held stable.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `if_valid`=0, `if_pc`=0, `if_instr`=NOP_INSTR.
  - `fetch_pc`=RESET_PC, `kill`=0, skid empty, state FETCH.
- First `imem_req` is in the first clock cycle after `rst_n` rises.
- Reset mid-transaction aborts everything. A response arriving after reset is dropped unless a request has since been granted.
- Best case (grant in the request cycle, `imem_rvalid` one cycle later, `if_ready`=1): one instruction every 2 cycles.
  - Fetch latency is 2 cycles from `imem_req` to `if_valid`.
- Redirect sampled at edge N: `imem_addr`=target with `imem_req`=1 in cycle N+1 if idle. If a killed request is in flight, the request is issued in the cycle after its response.
- `imem_req`, `imem_addr`, `if_*` outputs are all registered, or decoded from registered state only.

## Test plan
- Reset release, with the grant in the request cycle and rvalid in the next cycle: addresses 0x0, 0x4, 0x8; `if_pc` 0x0/0x4/0x8, one instruction every 2 cycles; `if_instr` matches memory.
- Hold `if_ready`=0 for 6 cycles after the first instruction: the skid fills, `imem_req` stays 0 and no instruction is lost or duplicated. The sequence resumes in order on release.
- Redirect with `branch`=01, `branch_target`=0x100 while in WAIT: the in-flight response is dropped and the next `imem_addr`=0x100. The first `if_pc` after the redirect is 0x100.
- `branch`=10, `alu_out`=0x203: the fetch goes to 0x200. `branch`=11 with `branch_valid`=1 has no effect on the sequence.
- Redirect in the same cycle as `imem_rvalid` with the buffer full and `if_ready`=1: the handshake completes, the old response is discarded and `if_valid`=0 the next cycle.
- Assert `rst_n`=0 mid-WAIT, then release: outputs return to reset values immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: next-PC select inputs, instruction-memory request port
// and the valid/ready handshake towards decode.
interface fetch_unit_if;
  logic [1:0]  branch;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] alu_out;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    input  branch,
    input  branch_valid,
    input  branch_target,
    input  alu_out,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    output branch,
    output branch_valid,
    output branch_target,
    output alu_out,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and hands
// instructions to decode through an output buffer backed by a one-entry skid.
module fetch_unit #(
  parameter logic [31:0] ResetPc  = 32'h0000_0000,
  parameter logic [31:0] NopInstr = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        kill_q, kill_d;
  logic        run_q;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;

  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic        redirect;
  logic        grant;
  logic        drain;
  logic [31:0] target;

  assign redirect = bus.branch_valid && ((bus.branch == 2'b01) || (bus.branch == 2'b10));
  assign target   = ((bus.branch == 2'b01) ? bus.branch_target : bus.alu_out) & 32'hFFFF_FFFC;

  // run_q keeps the request low until the first edge after reset release.
  assign bus.imem_req  = run_q && (state_q == StFetch) && !skid_valid_q;
  assign bus.imem_addr = fetch_pc_q;
  assign grant         = bus.imem_req && bus.imem_gnt;
  assign drain         = out_valid_q && bus.if_ready;

  assign bus.if_valid = out_valid_q;
  assign bus.if_pc    = out_pc_q;
  assign bus.if_instr = out_valid_q ? out_instr_q : NopInstr;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      StFetch: begin
        if (grant) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          state_d       = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = StFetch;
          end else if (!out_valid_q || drain) begin
            out_valid_d = 1'b1;
            out_pc_d    = inflight_pc_q;
            out_instr_d = bus.imem_rdata;
            state_d     = StFetch;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = inflight_pc_q;
            skid_instr_d = bus.imem_rdata;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (drain) begin
          out_valid_d  = 1'b1;
          out_pc_d     = skid_pc_q;
          out_instr_d  = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    // Redirect overrides everything above; a request still in flight must be killed.
    if (redirect) begin
      fetch_pc_d   = target;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        StFetch: begin
          if (grant) begin
            kill_d  = 1'b1;
            state_d = StWait;
          end else begin
            state_d = StFetch;
          end
        end
        StWait: begin
          if (bus.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = StFetch;
          end else begin
            kill_d  = 1'b1;
            state_d = StWait;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      fetch_pc_q    <= ResetPc;
      inflight_pc_q <= ResetPc;
      kill_q        <= 1'b0;
      run_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= 32'h0;
      out_instr_q   <= NopInstr;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= NopInstr;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      run_q         <= 1'b1;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
    end
  end

  a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_req |-> (bus.imem_addr[1:0] == 2'b00));

  a_skid_implies_buf : assert property (@(posedge clk) disable iff (!rst_n)
    skid_valid_q |-> out_valid_q);

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.if_ready && !redirect)
      |=> (out_valid_q && $stable(out_pc_q) && $stable(out_instr_q)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected addresses and PCs,
// independent monitors compare granted addresses and decode handshakes.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          budget  = 0;
  int          rv_delay = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];

  localparam logic [31:0] Nop = 32'h0000_0013;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string name);
    check({name, "_pc_sb"}, 32'(exp_pc_q.size()), 32'd0);
    check({name, "_addr_sb"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  // Memory model: grants while budget lasts, answers rv_delay+1 cycles after the grant.
  initial begin : responder
    logic        fire;
    logic        busy;
    logic [31:0] faddr;
    logic [31:0] a;
    int          cnt;
    busy = 1'b0;
    cnt  = 0;
    a    = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      fire  = bus.imem_req && bus.imem_gnt;
      faddr = bus.imem_addr;
      @(posedge clk);
      #2;
      bus.imem_rvalid = 1'b0;
      if (fire) begin
        busy = 1'b1;
        cnt  = rv_delay;
        a    = faddr;
        if (budget > 0) budget--;
      end else if (busy && cnt > 0) begin
        cnt--;
      end
      if (busy && cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(a);
        busy = 1'b0;
      end
      bus.imem_gnt = (budget > 0);
    end
  end

  initial begin : addr_mon
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req && bus.imem_gnt) begin
        if (exp_addr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL addr_unexpected: got %h, expected no grant", bus.imem_addr);
        end else begin
          check("imem_addr", bus.imem_addr, exp_addr_q.pop_front());
        end
      end
    end
  end

  initial begin : out_mon
    logic        hold_prev;
    logic [31:0] pc_prev;
    logic [31:0] instr_prev;
    logic [31:0] e;
    hold_prev  = 1'b0;
    pc_prev    = 32'h0;
    instr_prev = 32'h0;
    forever begin
      @(negedge clk);
      if (hold_prev && rst_n && bus.if_valid) begin
        check("hold_pc", bus.if_pc, pc_prev);
        check("hold_instr", bus.if_instr, instr_prev);
      end
      if (rst_n && bus.if_valid && bus.if_ready) begin
        if (exp_pc_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL if_pc_unexpected: got %h, expected no transfer", bus.if_pc);
        end else begin
          e = exp_pc_q.pop_front();
          check("if_pc", bus.if_pc, e);
          check("if_instr", bus.if_instr, mem_word(e));
        end
      end
      hold_prev  = rst_n && bus.if_valid && !bus.if_ready;
      pc_prev    = bus.if_pc;
      instr_prev = bus.if_instr;
    end
  end

  initial begin : main
    rst_n             = 1'b0;
    bus.if_ready      = 1'b1;
    bus.branch        = 2'b00;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'h0;
    bus.alu_out       = 32'h0;
    repeat (2) step();

    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_pc", bus.if_pc, 32'h0);
    check("rst_instr", bus.if_instr, Nop);

    // Reset release, back-to-back fetches 0/4/8.
    rst_n  = 1'b1;
    budget = 3;
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_pc_q   = '{32'h0, 32'h4, 32'h8};
    step();
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
    step();
    check("lat_valid_lo", 32'(bus.if_valid), 32'd0);
    step();
    check("lat_valid_hi", 32'(bus.if_valid), 32'd1);
    check("lat_pc", bus.if_pc, 32'h0);
    check("lat_instr", bus.if_instr, 32'hA5C3_0000);
    step();
    check("rate_gap", 32'(bus.if_valid), 32'd0);
    step();
    check("rate_valid", 32'(bus.if_valid), 32'd1);
    check("rate_pc", bus.if_pc, 32'h4);
    repeat (6) step();
    check_empty("seq");

    // Backpressure: the skid fills and requests stop until decode drains.
    bus.if_ready = 1'b0;
    budget = 3;
    exp_addr_q = '{32'hC, 32'h10, 32'h14};
    exp_pc_q   = '{32'hC, 32'h10, 32'h14};
    step();
    step();
    check("stall_valid", 32'(bus.if_valid), 32'd1);
    check("stall_pc", bus.if_pc, 32'hC);
    for (int i = 0; i < 6; i++) begin
      step();
      check("stall_req", 32'(bus.imem_req), 32'd0);
      check("stall_hold_pc", bus.if_pc, 32'hC);
    end
    bus.if_ready = 1'b1;
    step();
    check("skid_pc", bus.if_pc, 32'h10);
    repeat (5) step();
    check_empty("skid");

    // Redirect (branch target) while a slow response is in flight.
    rv_delay = 2;
    budget   = 2;
    exp_addr_q = '{32'h18, 32'h100};
    exp_pc_q   = '{32'h100};
    step();
    bus.branch        = 2'b01;
    bus.branch_target = 32'h100;
    bus.branch_valid  = 1'b1;
    step();
    bus.branch_valid = 1'b0;
    check("kill_req", 32'(bus.imem_req), 32'd0);
    check("kill_fetch_pc", bus.imem_addr, 32'h100);
    step();
    check("kill_req2", 32'(bus.imem_req), 32'd0);
    step();
    check("kill_resume_req", 32'(bus.imem_req), 32'd1);
    check("kill_resume_addr", bus.imem_addr, 32'h100);
    check("kill_drop", 32'(bus.if_valid), 32'd0);
    repeat (8) step();
    check_empty("kill");
    rv_delay = 0;

    // branch=11 is ignored.
    budget = 1;
    exp_addr_q = '{32'h104};
    exp_pc_q   = '{32'h104};
    bus.branch        = 2'b11;
    bus.branch_target = 32'h500;
    bus.alu_out       = 32'h600;
    bus.branch_valid  = 1'b1;
    step();
    step();
    bus.branch_valid = 1'b0;
    check("rsvd_no_redirect", bus.imem_addr, 32'h108);
    repeat (4) step();
    check_empty("rsvd");

    // ALU jump with misaligned target while idle.
    bus.branch       = 2'b10;
    bus.alu_out      = 32'h203;
    bus.branch_valid = 1'b1;
    step();
    bus.branch_valid = 1'b0;
    check("alu_req", 32'(bus.imem_req), 32'd1);
    check("alu_addr", bus.imem_addr, 32'h200);
    budget = 1;
    exp_addr_q = '{32'h200};
    exp_pc_q   = '{32'h200};
    repeat (5) step();
    check_empty("alu");

    // Redirect coincident with rvalid and a draining full buffer.
    bus.if_ready = 1'b0;
    budget = 2;
    exp_addr_q = '{32'h204, 32'h208};
    exp_pc_q   = '{32'h204};
    step();
    step();
    check("same_cyc_valid", 32'(bus.if_valid), 32'd1);
    check("same_cyc_pc", bus.if_pc, 32'h204);
    step();
    bus.if_ready      = 1'b1;
    bus.branch        = 2'b01;
    bus.branch_target = 32'h301;
    bus.branch_valid  = 1'b1;
    step();
    bus.branch_valid = 1'b0;
    check("same_cyc_drop", 32'(bus.if_valid), 32'd0);
    check("same_cyc_req", 32'(bus.imem_req), 32'd1);
    check("same_cyc_addr", bus.imem_addr, 32'h300);
    repeat (4) step();
    check_empty("same_cyc");

    // Reset while waiting on a response, with an instruction parked in the buffer.
    bus.if_ready = 1'b0;
    rv_delay = 2;
    budget   = 2;
    exp_addr_q = '{32'h300, 32'h304};
    repeat (6) step();
    check("pre_rst_valid", 32'(bus.if_valid), 32'd1);
    check("pre_rst_pc", bus.if_pc, 32'h300);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.imem_req), 32'd0);
    check("mid_rst_addr", bus.imem_addr, 32'h0);
    check("mid_rst_valid", 32'(bus.if_valid), 32'd0);
    check("mid_rst_pc", bus.if_pc, 32'h0);
    check("mid_rst_instr", bus.if_instr, Nop);
    step();
    rst_n        = 1'b1;
    bus.if_ready = 1'b1;
    rv_delay     = 0;
    budget       = 2;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_pc_q = '{32'h0, 32'h4};
    step();
    check("restart_req", 32'(bus.imem_req), 32'd1);
    check("restart_addr", bus.imem_addr, 32'h0);
    check("stale_dropped", 32'(bus.if_valid), 32'd0);
    repeat (8) step();
    check_empty("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
